// File: rtl/fir_low_pass_if.sv
// Output bundle of the FIR low-pass demonstrator: filtered sample plus its
// one-cycle valid strobe. The filter drives it (master), a consumer reads it.
interface fir_low_pass_if;
    logic signed [12:0] fir_out;
    logic               fir_out_en;

    modport master (
        output fir_out,
        output fir_out_en
    );

    modport slave (
        input fir_out,
        input fir_out_en
    );
endinterface

// File: rtl/fir_low_pass.sv
// FIR low-pass demonstrator. Generates a triangle wave with a superimposed
// Nyquist-rate square component, runs it through an 8-tap symmetric FIR
// (h = 1,2,5,8,8,5,2,1) whose alternating-sign sum is zero, and presents the
// full-precision result with a one-cycle strobe per sample.
module fir_low_pass #(
    parameter int SAMPLE_DIV = 4,   // clock cycles per input sample (>= 2)
    parameter int TRI_STEP   = 4,   // triangle increment per sample
    parameter int TRI_MAX    = 60,  // triangle peak, multiple of TRI_STEP, <= 64
    parameter int HF_AMP     = 32   // square component magnitude, <= 63
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    fir_low_pass_if.master out_if
);

    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic signed [7:0] STEP_V   = 8'(TRI_STEP);
    localparam logic signed [7:0] MAX_V    = 8'(TRI_MAX);
    localparam logic signed [7:0] AMP_V    = 8'(HF_AMP);

    logic [CNT_W-1:0]   cnt_r;
    logic               strobe_s;
    logic signed [7:0]  t_r;
    logic               dir_down_r;
    logic               hp_r;
    logic signed [7:0]  x_s;
    logic signed [7:0]  dly_r [0:7];
    logic               pend_r;
    logic signed [12:0] y_s;

    // Fixed low-pass taps; index 0 multiplies the newest sample.
    function automatic logic signed [12:0] coef_f(input logic [2:0] k);
        logic signed [12:0] c;
        case (k)
            3'd0:    c = 13'sd1;
            3'd1:    c = 13'sd2;
            3'd2:    c = 13'sd5;
            3'd3:    c = 13'sd8;
            3'd4:    c = 13'sd8;
            3'd5:    c = 13'sd5;
            3'd6:    c = 13'sd2;
            3'd7:    c = 13'sd1;
            default: c = 13'sd0;
        endcase
        return c;
    endfunction

    // Sample-rate divider: strobe fires in the last cycle of each period.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign strobe_s = (cnt_r == CNT_LAST);

    // Current stimulus sample: triangle plus or minus the square amplitude.
    always_comb begin
        if (hp_r) begin
            x_s = t_r - AMP_V;
        end else begin
            x_s = t_r + AMP_V;
        end
    end

    // Stimulus generator: triangle bounces between -TRI_MAX and +TRI_MAX,
    // square phase flips every sample.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            t_r        <= 8'sd0;
            dir_down_r <= 1'b0;
            hp_r       <= 1'b0;
        end else if (strobe_s) begin
            hp_r <= ~hp_r;
            if (!dir_down_r) begin
                if (t_r == MAX_V) begin
                    dir_down_r <= 1'b1;
                    t_r        <= t_r - STEP_V;
                end else begin
                    t_r <= t_r + STEP_V;
                end
            end else begin
                if (t_r == -MAX_V) begin
                    dir_down_r <= 1'b0;
                    t_r        <= t_r + STEP_V;
                end else begin
                    t_r <= t_r - STEP_V;
                end
            end
        end
    end

    // Delay line: shift the new sample in on each strobe, d0 newest.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < 8; i++) begin
                dly_r[i] <= 8'sd0;
            end
        end else if (strobe_s) begin
            dly_r[0] <= x_s;
            for (int i = 1; i < 8; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    // Full-precision convolution of the delay line; |y| <= 4096 fits 13 bits.
    always_comb begin
        y_s = 13'sd0;
        for (int i = 0; i < 8; i++) begin
            y_s = y_s + coef_f(3'(i)) * 13'(dly_r[i]);
        end
    end

    // Output stage: one cycle after the delay line loads, register y and
    // raise the strobe for exactly one cycle; fir_out holds between strobes.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pend_r            <= 1'b0;
            out_if.fir_out    <= 13'sd0;
            out_if.fir_out_en <= 1'b0;
        end else begin
            pend_r            <= strobe_s;
            out_if.fir_out_en <= pend_r;
            if (pend_r) begin
                out_if.fir_out <= y_s;
            end else begin
                out_if.fir_out <= out_if.fir_out;
            end
        end
    end

endmodule

// File: tb/tb_fir_low_pass.sv
// Directed bench for fir_low_pass: four parameterisations side by side
// (default, square-only, ramp-only, all-zero) sharing clock and reset.
module tb_fir_low_pass;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    always #5 sys_clk = ~sys_clk;

    fir_low_pass_if if_def ();
    fir_low_pass_if if_hf ();
    fir_low_pass_if if_ramp ();
    fir_low_pass_if if_zero ();

    fir_low_pass u_def (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .out_if  (if_def)
    );

    fir_low_pass #(.TRI_STEP(0)) u_hf (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .out_if  (if_hf)
    );

    fir_low_pass #(.HF_AMP(0)) u_ramp (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .out_if  (if_ramp)
    );

    fir_low_pass #(.TRI_STEP(0), .HF_AMP(0)) u_zero (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .out_if  (if_zero)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    int y_def  [64];
    int y_hf   [64];
    int y_ramp [64];
    int en_cyc [64];
    int n_def, n_hf, n_ramp, n_zero, zero_bad;

    int exp_def [5]  = '{32, 36, 144, 176, 240};
    int exp_hf  [12] = '{32, 32, 128, 128, 128, 32, 32, 0, 0, 0, 0, 0};

    task automatic check_val(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run ncyc cycles after reset release; cycle 0 is the first non-reset
    // cycle, and values seen after edge c belong to cycle c+1.
    task automatic capture(input int ncyc);
        n_def = 0; n_hf = 0; n_ramp = 0; n_zero = 0; zero_bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge sys_clk);
            #1;
            if (if_def.fir_out_en) begin
                if (n_def < 64) begin
                    y_def[n_def]  = int'(if_def.fir_out);
                    en_cyc[n_def] = c + 1;
                end
                n_def++;
            end
            if (if_hf.fir_out_en) begin
                if (n_hf < 64) y_hf[n_hf] = int'(if_hf.fir_out);
                n_hf++;
            end
            if (if_ramp.fir_out_en) begin
                if (n_ramp < 64) y_ramp[n_ramp] = int'(if_ramp.fir_out);
                n_ramp++;
            end
            if (if_zero.fir_out_en) begin
                n_zero++;
                if (if_zero.fir_out != 13'sd0) zero_bad++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            y_def[i] = 0; y_hf[i] = 0; y_ramp[i] = 0; en_cyc[i] = 0;
        end

        // Reset held for 10 cycles: outputs stay cleared.
        @(posedge sys_clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check_val("rst_out", int'(if_def.fir_out), 0);
            check_val("rst_en", int'(if_def.fir_out_en), 0);
        end
        sys_rst = 1'b0;

        capture(170);

        // Strobe timing: first at cycle SAMPLE_DIV+1, then every 4 cycles.
        check_val("def_count", n_def, 42);
        check_val("first_en", en_cyc[0], 5);
        for (int i = 1; i < 6; i++) begin
            check_val("en_period", en_cyc[i] - en_cyc[i-1], 4);
        end

        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("def_y%0d", i), y_def[i], exp_def[i]);
        end

        for (int i = 0; i < 12; i++) begin
            check_val($sformatf("hf_y%0d", i), y_hf[i], exp_hf[i]);
        end

        // Ramp rise y_n = 128n-448; falling side mirrors about n = 18.5.
        check_val("ramp_count", n_ramp, 42);
        for (int n = 7; n <= 15; n++) begin
            check_val($sformatf("ramp_y%0d", n), y_ramp[n], 128 * n - 448);
        end
        for (int n = 22; n <= 28; n++) begin
            check_val($sformatf("ramp_y%0d", n), y_ramp[n], 128 * (37 - n) - 448);
        end

        check_val("zero_count", n_zero, 42);
        check_val("zero_nonzero", zero_bad, 0);

        // One-cycle reset mid-run clears the output on the next edge.
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check_val("midrst_out", int'(if_def.fir_out), 0);
        check_val("midrst_en", int'(if_def.fir_out_en), 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        capture(30);
        check_val("re_count", n_def, 7);
        check_val("re_first_en", en_cyc[0], 5);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("re_y%0d", i), y_def[i], exp_def[i]);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
